// File: rtl/pmem_arbiter.sv
// Purpose: shares one physical-memory line port between icache and dcache, round-robin on ties, grant held until pmem_resp.
// Latency: request sampled at edge N drives pmem at N+1; pmem_resp/rdata pass through combinationally; DONE+IDLE gap between grants.
// Backpressure: clients hold read/write until their resp pulse; a waiting client is never served mid-grant (no pre-emption).
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;
  typedef enum logic {CL_I, CL_D} client_t;

  state_t  state;
  client_t last_grant;
  logic    req_i;
  logic    req_d;

  assign req_i = i_pmem_read | i_pmem_write;
  assign req_d = d_pmem_read | d_pmem_write;

  // Grant FSM: arbitrate in IDLE, hold grant until memory completes, then one bubble cycle.
  // last_grant resets to dcache so the icache wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= CL_D;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && (!req_d || last_grant == CL_D)) begin
            state <= GNT_I;
          end else if (req_d) begin
            state <= GNT_D;
          end
        end
        GNT_I: begin
          if (pmem_resp) begin
            last_grant <= CL_I;
            state      <= DONE;
          end
        end
        GNT_D: begin
          if (pmem_resp) begin
            last_grant <= CL_D;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Steer the granted client onto the memory port and route the completion back to it only.
  // Outside a grant everything is zero, so a stray pmem_resp never reaches either cache.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    case (state)
      GNT_I: begin
        pmem_read    = i_pmem_read;
        pmem_write   = i_pmem_write;
        pmem_address = i_pmem_address;
        pmem_wdata   = i_pmem_wdata;
        i_pmem_resp  = pmem_resp;
        i_pmem_rdata = pmem_rdata;
      end
      GNT_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        d_pmem_rdata = pmem_rdata;
      end
      default: ;
    endcase
  end

  // A client asking to read and write the same line at once is malformed; it is forwarded as-is but flagged.
  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(pmem_read && pmem_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef struct {
    bit                is_d;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              i_pmem_read, i_pmem_write, i_pmem_resp;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_wdata, i_pmem_rdata;
  logic              d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata, d_pmem_rdata;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   mem_lat = 5;
  int   spur_cnt = 0;
  int   spur_seen = 0;
  int   cnt = 0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write), .i_pmem_address(i_pmem_address),
    .i_pmem_wdata(i_pmem_wdata), .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write), .d_pmem_address(d_pmem_address),
    .d_pmem_wdata(d_pmem_wdata), .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input logic [31:0] word);
    exp_t e;
    e.is_d = is_d;
    e.data = {8{word}};
    sb.push_back(e);
  endtask

  task automatic wait_resp(input bit is_d, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = is_d ? d_pmem_resp : i_pmem_resp;
    end
    if (!seen) check(nm, {255'b0, seen}, 1);
  endtask

  task automatic check_port(input string nm, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [LINE_W-1:0] wd);
    check({nm, "_read"}, pmem_read, rd);
    check({nm, "_write"}, pmem_write, wr);
    check({nm, "_addr"}, pmem_address, addr);
    check({nm, "_wdata"}, pmem_wdata, wd);
  endtask

  // Memory model: completes any request after mem_lat cycles with rdata = {8{addr ^ DEADBEEF}}.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else if (spur_cnt != spur_seen) begin
        spur_seen  = spur_cnt;
        pmem_rdata = {8{32'h5A5A_5A5A}};
        pmem_resp  = 1'b1;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt        = 0;
          pmem_rdata = {8{pmem_address ^ 32'hDEAD_BEEF}};
          pmem_resp  = 1'b1;
        end
      end
    end
  end

  // Monitor: every client completion must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_pmem_resp && d_pmem_resp) begin
        check("dual_resp", {255'b0, i_pmem_resp & d_pmem_resp}, 0);
      end else if (i_pmem_resp || d_pmem_resp) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", {254'b0, i_pmem_resp, d_pmem_resp}, 0);
        end else begin
          e = sb.pop_front();
          check("resp_client", {255'b0, d_pmem_resp}, {255'b0, e.is_d});
          check("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    #2;
    check_port("reset", 0, 0, 32'h0, '0);
    check("reset_i_resp", i_pmem_resp, 0);
    check("reset_d_resp", d_pmem_resp, 0);
    tick();
    rst_n = 1'b1;

    // Icache read alone
    tick();
    i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    push(0, 32'hDEAD_AEEF);
    @(posedge clk); @(negedge clk);
    check_port("ird", 1, 0, 32'h1000, '0);
    wait_resp(0, "ird_timeout");
    tick();
    i_pmem_read = 0;
    @(negedge clk);
    check("ird_done_read", pmem_read, 0);

    // Dcache writeback
    repeat (2) tick();
    d_pmem_write = 1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = {32{8'hA5}};
    push(1, 32'hDEAD_9EAF);
    @(posedge clk); @(negedge clk);
    check_port("dwb", 0, 1, 32'h2040, {32{8'hA5}});
    wait_resp(1, "dwb_timeout");
    tick();
    d_pmem_write = 0; d_pmem_wdata = '0;

    // Tie straight after reset: icache first, then dcache, next tie icache again
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_pmem_read = 1; i_pmem_address = 32'h3000;
    d_pmem_read = 1; d_pmem_address = 32'h4000;
    push(0, 32'hDEAD_8EEF);
    push(1, 32'hDEAD_FEEF);
    @(posedge clk); @(negedge clk);
    check_port("tie1_i", 1, 0, 32'h3000, '0);
    wait_resp(0, "tie1_i_timeout");
    tick();
    i_pmem_read = 0;
    @(negedge clk);
    check("tie1_gap_done", pmem_read, 0);
    @(negedge clk);
    check("tie1_gap_idle", pmem_read, 0);
    @(negedge clk);
    check_port("tie1_d", 1, 0, 32'h4000, '0);
    wait_resp(1, "tie1_d_timeout");
    tick();
    d_pmem_read = 0;
    repeat (2) tick();
    i_pmem_read = 1; i_pmem_address = 32'h5000;
    d_pmem_read = 1; d_pmem_address = 32'h6000;
    push(0, 32'hDEAD_EEEF);
    push(1, 32'hDEAD_DEEF);
    @(posedge clk); @(negedge clk);
    check_port("tie2_i", 1, 0, 32'h5000, '0);
    wait_resp(0, "tie2_i_timeout");
    tick();
    i_pmem_read = 0;
    repeat (3) @(negedge clk);
    check_port("tie2_d", 1, 0, 32'h6000, '0);
    wait_resp(1, "tie2_d_timeout");
    tick();
    d_pmem_read = 0;

    // Dcache arrives mid icache grant: no pre-emption
    repeat (2) tick();
    i_pmem_read = 1; i_pmem_address = 32'h7000;
    push(0, 32'hDEAD_CEEF);
    repeat (2) tick();
    d_pmem_write = 1; d_pmem_address = 32'h8000; d_pmem_wdata = {32{8'h3C}};
    push(1, 32'hDEAD_3EEF);
    @(negedge clk);
    check_port("sticky_a", 1, 0, 32'h7000, '0);
    tick();
    @(negedge clk);
    check_port("sticky_b", 1, 0, 32'h7000, '0);
    wait_resp(0, "sticky_i_timeout");
    tick();
    i_pmem_read = 0;
    repeat (3) @(negedge clk);
    check_port("sticky_d", 0, 1, 32'h8000, {32{8'h3C}});
    wait_resp(1, "sticky_d_timeout");
    tick();
    d_pmem_write = 0; d_pmem_wdata = '0;

    // Spurious pmem_resp while idle
    repeat (2) tick();
    #2;
    spur_cnt++;
    @(negedge clk);
    @(negedge clk);
    check("spur_pulse", pmem_resp, 1);
    check("spur_i_resp", i_pmem_resp, 0);
    check("spur_d_resp", d_pmem_resp, 0);
    @(negedge clk);
    check_port("spur_after", 0, 0, 32'h0, '0);

    // Reset during a dcache grant, icache pending
    mem_lat = 20;
    tick();
    d_pmem_read = 1; d_pmem_address = 32'h9000;
    @(posedge clk); @(negedge clk);
    check_port("rst_gnt_d", 1, 0, 32'h9000, '0);
    tick();
    i_pmem_read = 1; i_pmem_address = 32'hA000;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_port("rst_async", 0, 0, 32'h0, '0);
    check("rst_async_d_resp", d_pmem_resp, 0);
    d_pmem_read = 0;
    mem_lat = 3;
    push(0, 32'hDEAD_1EEF);
    repeat (2) tick();
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_port("post_rst_i", 1, 0, 32'hA000, '0);
    wait_resp(0, "post_rst_i_timeout");
    tick();
    i_pmem_read = 0;

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
